// File: rtl/tmr_piso_tx_ctrl.sv
// Upstream sequencer for the triplicated PISO shift register: takes parallel words over
// valid/ready, loads the register, then qualifies its voted serial output LSB first.
module tmr_piso_tx_ctrl #(
  parameter int width = 8,
  parameter int cnt_w = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             reg_enable,
  output logic             reg_load,
  output logic [1:0]       reg_mode,
  output logic             reg_serial_in,
  output logic [width-1:0] reg_parallel_in,
  input  logic             reg_serial_out,
  output logic             tx_bit,
  output logic             tx_bit_valid,
  output logic             tx_last,
  output logic             busy,
  output logic             done,
  input  logic             seu_strobe,
  input  logic [1:0]       seu_sel,
  output logic             tmr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  localparam logic [cnt_w-1:0] LAST_CNT = cnt_w'(width - 1);

  function automatic logic [1:0] vote_state(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [cnt_w-1:0] vote_cnt(input logic [cnt_w-1:0] a,
                                                input logic [cnt_w-1:0] b,
                                                input logic [cnt_w-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0]       r_state [3];
  logic [cnt_w-1:0] r_cnt   [3];
  logic [width-1:0] r_data;
  logic             r_in_ready;
  logic             r_enable;
  logic             r_load;
  logic             r_tx_bit_valid;
  logic             r_tx_last;
  logic             r_done;
  logic             r_tmr_err;

  state_t           w_state;
  state_t           w_nstate;
  logic [cnt_w-1:0] w_cnt;
  logic [cnt_w-1:0] w_ncnt;
  logic             w_last;
  logic             w_accept;
  logic             w_mis;

  assign w_state = state_t'(vote_state(r_state[0], r_state[1], r_state[2]));
  assign w_cnt   = vote_cnt(r_cnt[0], r_cnt[1], r_cnt[2]);
  assign w_last  = (w_state == SHIFT) && (w_cnt == LAST_CNT);

  // Next state is always derived from the voted value, so every copy is rewritten each cycle.
  always_comb begin
    w_nstate = w_state;
    w_ncnt   = w_cnt;
    w_accept = 1'b0;
    case (w_state)
      IDLE: begin
        if (in_valid) begin
          w_nstate = LOAD;
          w_accept = 1'b1;
        end
      end
      LOAD: begin
        w_ncnt   = '0;
        w_nstate = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        w_ncnt   = w_last ? '0 : w_cnt + cnt_w'(1);
        w_nstate = (w_last || abort) ? IDLE : SHIFT;
      end
      default: begin
        w_nstate = IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_mis = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((r_state[i] != w_state) || (r_cnt[i] != w_cnt)) w_mis = 1'b1;
    end
  end

  // Outputs are registered from the voted next state so they line up with the FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
      r_data         <= '0;
      r_in_ready     <= 1'b1;
      r_enable       <= 1'b0;
      r_load         <= 1'b0;
      r_tx_bit_valid <= 1'b0;
      r_tx_last      <= 1'b0;
      r_done         <= 1'b0;
      r_tmr_err      <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= w_nstate;
        r_cnt[i]   <= w_ncnt ^ ((seu_strobe && (seu_sel == 2'(i))) ? cnt_w'(1) : '0);
      end
      if (w_accept) r_data <= in_data;
      r_in_ready     <= (w_nstate == IDLE);
      r_enable       <= (w_nstate != IDLE);
      r_load         <= (w_nstate == LOAD);
      r_tx_bit_valid <= (w_nstate == SHIFT);
      r_tx_last      <= (w_nstate == SHIFT) && (w_ncnt == LAST_CNT);
      r_done         <= w_last && !abort;
      r_tmr_err      <= w_mis;
    end
  end

  assign in_ready        = r_in_ready;
  assign reg_enable      = r_enable;
  assign reg_load        = r_load;
  assign reg_mode        = 2'b10;
  assign reg_serial_in   = 1'b0;
  assign reg_parallel_in = r_data;
  assign tx_bit          = reg_serial_out;
  assign tx_bit_valid    = r_tx_bit_valid;
  assign tx_last         = r_tx_last;
  assign busy            = r_enable;
  assign done            = r_done;
  assign tmr_err         = r_tmr_err;

endmodule

// File: tb/tb_tmr_piso_tx_ctrl.sv
// Scoreboard bench for tmr_piso_tx_ctrl with a behavioural PISO register on the far side.
module tb_tmr_piso_tx_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         abort = 1'b0;
  logic         reg_enable;
  logic         reg_load;
  logic [1:0]   reg_mode;
  logic         reg_serial_in;
  logic [W-1:0] reg_parallel_in;
  logic         reg_serial_out;
  logic         tx_bit;
  logic         tx_bit_valid;
  logic         tx_last;
  logic         busy;
  logic         done;
  logic         seu_strobe = 1'b0;
  logic [1:0]   seu_sel = 2'd3;
  logic         tmr_err;

  tmr_piso_tx_ctrl #(.width(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .reg_enable(reg_enable), .reg_load(reg_load), .reg_mode(reg_mode),
    .reg_serial_in(reg_serial_in), .reg_parallel_in(reg_parallel_in),
    .reg_serial_out(reg_serial_out), .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid),
    .tx_last(tx_last), .busy(busy), .done(done), .seu_strobe(seu_strobe),
    .seu_sel(seu_sel), .tmr_err(tmr_err)
  );

  always #5 clk = ~clk;

  // Downstream shift register: load on enable+load, shift right on enable, serial_out = bit 0.
  logic [W-1:0] sh;
  always @(posedge clk or negedge rst) begin
    if (!rst) sh <= '0;
    else if (reg_enable) sh <= reg_load ? reg_parallel_in : {1'b0, sh[W-1:1]};
  end
  assign reg_serial_out = sh[0];

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // {in_ready, reg_enable, reg_load, reg_mode, reg_serial_in, tx_bit_valid, tx_last, busy, done, tmr_err}
  task automatic chk_reset(input string name);
    chk(name, int'({in_ready, reg_enable, reg_load, reg_mode, reg_serial_in,
                    tx_bit_valid, tx_last, busy, done, tmr_err}), 'h480);
    chk({name, "_pin"}, int'(reg_parallel_in), 0);
  endtask

  // bits: expected transmission order; a full 8-char string marks the last bit with tx_last.
  task automatic start_word(input logic [W-1:0] d, input string bits, input bit exp_done,
                            output int t);
    exp_t e;
    int   guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_send", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    t = cyc;
    for (int i = 0; i < bits.len(); i++) begin
      e.b    = (bits.getc(i) == "1");
      e.last = (i == W - 1);
      exp_q.push_back(e);
    end
    if (exp_done) done_q.push_back(t + W + 2);
  endtask

  // Monitor: pops expectations whenever the DUT presents a bit or a done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (tx_bit_valid) begin
      if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tx_bit", int'(tx_bit), int'(e.b));
        chk("tx_last", int'(tx_last), int'(e.last));
      end
    end else if (tx_last) begin
      chk("tx_last_no_valid", 1, 0);
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
    if (tmr_err) err_cnt++;
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, t2, e0;
    #12;
    chk_reset("reset_vals");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Single word A5
    start_word(8'hA5, "10100101", 1, t);
    tick();
    in_valid = 1'b0;
    chk("t1_load", int'(reg_load), 1);
    chk("t1_pin", int'(reg_parallel_in), 'hA5);
    chk("t1_ready_low", int'(in_ready), 0);
    chk("t1_busy", int'(busy), 1);
    tick(9);
    chk("t1_ready_at_done", int'(in_ready), 1);
    chk("t1_done", int'(done), 1);
    chk("t1_pin_hold", int'(reg_parallel_in), 'hA5);
    tick();

    // Back-to-back FF then 01 with in_valid held
    start_word(8'hFF, "11111111", 1, t);
    tick();
    in_data = 8'h01;
    tick(9);
    chk("t2_ready", int'(in_ready), 1);
    chk("t2_gap_valid0", int'(tx_bit_valid), 0);
    start_word(8'h01, "10000000", 1, t2);
    chk("t2_handshake_cycle", t2 - t, 10);
    tick();
    in_valid = 1'b0;
    chk("t2_gap_valid1", int'(tx_bit_valid), 0);
    chk("t2_load", int'(reg_load), 1);
    chk("t2_pin", int'(reg_parallel_in), 'h01);
    tick(10);

    // Abort on the 4th shift cycle of 3C, then 81 accepted with abort held in IDLE
    start_word(8'h3C, "0011", 0, t);
    tick();
    in_valid = 1'b0;
    tick(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_valid_drop", int'(tx_bit_valid), 0);
    chk("t3_ready", int'(in_ready), 1);
    chk("t3_enable_off", int'(reg_enable), 0);
    tick(6);
    abort = 1'b1;
    start_word(8'h81, "10000001", 1, t);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("t3_load_after_abort", int'(reg_load), 1);
    tick(10);

    // SEU on counter copy 1, then on the no-effect selector 3
    for (int k = 0; k < 2; k++) begin
      e0 = err_cnt;
      start_word(8'hA5, "10100101", 1, t);
      tick();
      in_valid = 1'b0;
      tick(3);
      seu_strobe = 1'b1;
      seu_sel = (k == 0) ? 2'd1 : 2'd3;
      tick();
      seu_strobe = 1'b0;
      seu_sel = 2'd3;
      chk("t4_err_early", int'(tmr_err), 0);
      tick();
      chk("t4_err_pulse", int'(tmr_err), (k == 0) ? 1 : 0);
      tick(6);
      chk("t4_err_count", err_cnt - e0, (k == 0) ? 1 : 0);
    end

    // Reset in the middle of a word, then a fresh 5A
    start_word(8'hC3, "110", 0, t);
    tick();
    in_valid = 1'b0;
    tick(4);
    rst = 1'b0;
    #1;
    chk_reset("t5_mid_reset");
    tick(2);
    rst = 1'b1;
    tick();
    chk("t5_ready_after", int'(in_ready), 1);
    start_word(8'h5A, "01011010", 1, t);
    tick();
    in_valid = 1'b0;
    tick(10);

    // Idle after reset: no activity for 20 cycles
    rst = 1'b0;
    #1;
    chk_reset("t6_reset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_idle_quiet", int'({reg_enable, tx_bit_valid, done}), 0);
    end

    tick(2);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
